// File: rtl/cfg_frame_loader.sv
// Framed configuration loader: parses SYNC/ADDR/DATA/CHK frames from a UART
// byte stream and issues single-cycle writes on the addr/data/en config bus.
// Malformed, corrupted, stalled or out-of-range frames raise frame_err and
// leave the bus untouched.
module cfg_frame_loader #(
  parameter int          DATA_WIDTH = 8,
  parameter int          ADDR_MAX   = 4,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter int          TIMEOUT    = 50000,
  localparam int         AW         = (ADDR_MAX < 1) ? 1 : $clog2(ADDR_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [AW-1:0]         addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  en,
  output logic                  frame_ok,
  output logic                  frame_err
);

  localparam int         NB      = (DATA_WIDTH <= 8) ? 1 : 2;
  localparam int         CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [7:0] AMAX8   = 8'(ADDR_MAX);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_CHK  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [7:0]            acc_q, acc_d;
  logic                  idx_q, idx_d;
  logic [7:0]            sh_addr_q, sh_addr_d;
  logic [15:0]           sh_data_q, sh_data_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  en_q, en_d;
  logic                  ok_q, ok_d;
  logic                  err_q, err_d;

  assign addr      = addr_q;
  assign data      = data_q;
  assign en        = en_q;
  assign frame_ok  = ok_q;
  assign frame_err = err_q;

  // Frame parser, checksum accumulator and inter-byte watchdog.
  // A byte arriving on the would-be timeout cycle takes priority.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    sh_addr_d = sh_addr_q;
    sh_data_d = sh_data_q;
    addr_d    = addr_q;
    data_d    = data_q;
    en_d      = 1'b0;
    ok_d      = 1'b0;
    err_d     = 1'b0;

    if (state_q == S_IDLE) cnt_d = '0;

    if (rx_valid) begin
      cnt_d = '0;
      case (state_q)
        S_IDLE: if (rx_data == SYNC_BYTE) state_d = S_ADDR;
        S_ADDR: begin
          sh_addr_d = rx_data;
          acc_d     = rx_data;
          idx_d     = 1'b0;
          state_d   = S_DATA;
        end
        S_DATA: begin
          // little-endian: first data byte is bits 7:0
          if (idx_q == 1'b0) sh_data_d[7:0]  = rx_data;
          else               sh_data_d[15:8] = rx_data;
          acc_d = acc_q ^ rx_data;
          idx_d = idx_q + 1'b1;
          if (idx_q == 1'(NB - 1)) state_d = S_CHK;
        end
        default: begin // S_CHK
          state_d = S_IDLE;
          // range check on the full 8-bit address byte, before truncation
          if ((rx_data == acc_q) && (sh_addr_q <= AMAX8)) begin
            addr_d = sh_addr_q[AW-1:0];
            data_d = sh_data_q[DATA_WIDTH-1:0];
            en_d   = 1'b1;
            ok_d   = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
        end
      endcase
    end else if (state_q != S_IDLE) begin
      if (cnt_q == TO_LAST) begin
        state_d = S_IDLE;
        cnt_d   = '0;
        err_d   = 1'b1;
      end else begin
        cnt_d   = cnt_q + CW'(1);
      end
    end
  end

  // State and output registers; reset abandons any partial frame silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      idx_q     <= 1'b0;
      sh_addr_q <= '0;
      sh_data_q <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      en_q      <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      sh_addr_q <= sh_addr_d;
      sh_data_q <= sh_data_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      en_q      <= en_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Directed bench for cfg_frame_loader: an 8-bit instance (TIMEOUT=20) and a
// 12-bit instance fed from a shared byte bus with separate valid strobes.
module tb_cfg_frame_loader;

  logic        clk, rst;
  logic [7:0]  rx_data;
  logic        rx_valid_a, rx_valid_b;

  logic [2:0]  addr_a, addr_b;
  logic [7:0]  data_a;
  logic [11:0] data_b;
  logic        en_a, ok_a, err_a;
  logic        en_b, ok_b, err_b;

  int n_chk = 0;
  int n_err = 0;
  int en_cnt_a = 0, err_cnt_a = 0, en_cnt_b = 0, err_cnt_b = 0, overlap = 0;
  int en_snap, err_snap;

  cfg_frame_loader #(.DATA_WIDTH(8), .ADDR_MAX(4), .SYNC_BYTE(8'hA5), .TIMEOUT(20)) u_a (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid_a),
    .addr(addr_a), .data(data_a), .en(en_a), .frame_ok(ok_a), .frame_err(err_a)
  );

  cfg_frame_loader #(.DATA_WIDTH(12), .ADDR_MAX(4), .SYNC_BYTE(8'hA5), .TIMEOUT(40)) u_b (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid_b),
    .addr(addr_b), .data(data_b), .en(en_b), .frame_ok(ok_b), .frame_err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pulse counters
  always @(posedge clk) begin
    if (en_a) en_cnt_a <= en_cnt_a + 1;
    if (err_a) err_cnt_a <= err_cnt_a + 1;
    if (en_b) en_cnt_b <= en_cnt_b + 1;
    if (err_b) err_cnt_b <= err_cnt_b + 1;
    if ((en_a && err_a) || (en_b && err_b)) overlap <= overlap + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; presents one byte for one cycle, returns at the next negedge.
  task automatic send(input logic [7:0] b, input bit to_b);
    rx_data = b;
    if (to_b) rx_valid_b = 1'b1; else rx_valid_a = 1'b1;
    @(negedge clk);
    rx_valid_a = 1'b0;
    rx_valid_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; rx_data = 8'h00; rx_valid_a = 1'b0; rx_valid_b = 1'b0;
    idle(3);
    chk("rst_en",   32'(en_a),   0);
    chk("rst_ok",   32'(ok_a),   0);
    chk("rst_err",  32'(err_a),  0);
    chk("rst_addr", 32'(addr_a), 0);
    chk("rst_data", 32'(data_a), 0);
    rst = 1'b0;
    idle(2);

    // good frame, spaced bytes
    send(8'hA5, 0); idle(2); send(8'h04, 0); idle(1); send(8'h1E, 0); idle(3);
    send(8'h1A, 0);
    chk("t1_en",   32'(en_a),   1);
    chk("t1_ok",   32'(ok_a),   1);
    chk("t1_err",  32'(err_a),  0);
    chk("t1_addr", 32'(addr_a), 4);
    chk("t1_data", 32'(data_a), 32'h1E);
    idle(1);
    chk("t1_en_clr", 32'(en_a), 0);
    chk("t1_ok_clr", 32'(ok_a), 0);
    idle(5);
    chk("t1_addr_hold", 32'(addr_a), 4);
    chk("t1_data_hold", 32'(data_a), 32'h1E);

    // bad checksum
    send(8'hA5, 0); send(8'h04, 0); send(8'h1E, 0); send(8'h1B, 0);
    chk("t2_err",  32'(err_a),  1);
    chk("t2_en",   32'(en_a),   0);
    idle(1);
    chk("t2_err_clr", 32'(err_a), 0);
    chk("t2_addr", 32'(addr_a), 4);
    chk("t2_data", 32'(data_a), 32'h1E);

    // address out of range, checksum correct
    send(8'hA5, 0); send(8'h05, 0); send(8'h10, 0); send(8'h15, 0);
    chk("t3_err",  32'(err_a),  1);
    chk("t3_en",   32'(en_a),   0);
    chk("t3_addr", 32'(addr_a), 4);
    idle(2);

    // timeout after ADDR byte
    en_snap = en_cnt_a;
    send(8'hA5, 0); send(8'h02, 0);
    idle(19);
    chk("t4_err_early", 32'(err_a), 0);
    idle(1);
    chk("t4_err_to", 32'(err_a), 1);
    chk("t4_en_to",  32'(en_a),  0);
    idle(1);
    chk("t4_err_clr", 32'(err_a), 0);
    err_snap = err_cnt_a;
    send(8'h33, 0); send(8'h21, 0); idle(2);
    chk("t4_no_en",  32'(en_cnt_a),  32'(en_snap));
    chk("t4_no_err", 32'(err_cnt_a), 32'(err_snap));

    // reset mid-frame
    en_snap = en_cnt_a;
    err_snap = err_cnt_a;
    send(8'hA5, 0); send(8'h03, 0);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    chk("t5_rst_addr", 32'(addr_a), 0);
    chk("t5_rst_data", 32'(data_a), 0);
    send(8'h7F, 0); send(8'h7C, 0); idle(2);
    chk("t5_no_en",  32'(en_cnt_a),  32'(en_snap));
    chk("t5_no_err", 32'(err_cnt_a), 32'(err_snap));
    send(8'hA5, 0); send(8'h03, 0); send(8'h7F, 0); send(8'h7C, 0);
    chk("t5_en",   32'(en_a),   1);
    chk("t5_addr", 32'(addr_a), 3);
    chk("t5_data", 32'(data_a), 32'h7F);
    idle(2);

    // 12-bit instance, back-to-back frames
    send(8'hA5, 1); send(8'h01, 1); send(8'h34, 1); send(8'h0A, 1); send(8'h3F, 1);
    chk("t6_en1",   32'(en_b),   1);
    chk("t6_ok1",   32'(ok_b),   1);
    chk("t6_addr1", 32'(addr_b), 1);
    chk("t6_data1", 32'(data_b), 32'hA34);
    send(8'hA5, 1);
    chk("t6_en_gap", 32'(en_b), 0);
    send(8'h02, 1); send(8'hFF, 1); send(8'h00, 1); send(8'hFD, 1);
    chk("t6_en2",   32'(en_b),   1);
    chk("t6_addr2", 32'(addr_b), 2);
    chk("t6_data2", 32'(data_b), 32'h0FF);
    idle(1);
    chk("t6_en_clr", 32'(en_b), 0);
    idle(2);

    chk("b_en_count",  32'(en_cnt_b),  2);
    chk("b_err_count", 32'(err_cnt_b), 0);
    chk("en_err_overlap", 32'(overlap), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
